// File: rtl/float_copro_ctrl.sv
// float_copro_ctrl: sequencer that holds opcode/operands steady for a multicycle float datapath
module float_copro_ctrl #(
  parameter int LATENCY = 4,
  parameter int NUM_OPS = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        user_valid,
  input  logic [10:0] user_opcode,
  input  logic [31:0] user_operand_0,
  input  logic [31:0] user_operand_1,
  output logic [31:0] user_result,
  output logic        user_complete,
  output logic        user_error,
  output logic        busy,
  output logic [10:0] dp_opcode,
  output logic [31:0] dp_op0,
  output logic [31:0] dp_op1,
  input  logic [31:0] dp_result
);
  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] EXEC = 2'd1;
  localparam logic [1:0] DONE = 2'd2;
  localparam logic [10:0] N_OPS = 11'(NUM_OPS);
  localparam logic [3:0] CNT_INIT = 4'(LATENCY - 1);
  logic [1:0] state;
  logic [3:0] cnt;
  logic       err;
  assign busy = state != IDLE;
  // FSM: capture in IDLE, count down in EXEC, pulse completion from DONE
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
      cnt <= 4'd0;
      err <= 1'b0;
      user_result <= 32'd0;
      user_complete <= 1'b0;
      user_error <= 1'b0;
      dp_opcode <= 11'd0;
      dp_op0 <= 32'd0;
      dp_op1 <= 32'd0;
    end else begin
      user_complete <= 1'b0;
      user_error <= 1'b0;
      case (state)
        IDLE: if (user_valid) begin
          if (user_opcode < N_OPS) begin
            dp_opcode <= user_opcode;
            dp_op0 <= user_operand_0;
            dp_op1 <= user_operand_1;
            cnt <= CNT_INIT;
            err <= 1'b0;
            state <= EXEC;
          end else begin
            user_result <= 32'd0;
            err <= 1'b1;
            state <= DONE;
          end
        end
        EXEC: if (cnt == 4'd0) begin
          user_result <= dp_result;
          state <= DONE;
        end else cnt <= cnt - 4'd1;
        DONE: begin
          user_complete <= 1'b1;
          user_error <= err;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_float_copro_ctrl.sv
// tb_float_copro_ctrl: random and directed checks of two builds (LATENCY 4 and 1) against a transaction model
module tb_float_copro_ctrl;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic        rst_n [2];
  logic        v     [2];
  logic [10:0] opc   [2];
  logic [31:0] a     [2];
  logic [31:0] b     [2];
  logic [31:0] res   [2];
  logic        cmp   [2];
  logic        err   [2];
  logic        bsy   [2];
  logic [10:0] dpo   [2];
  logic [31:0] dp0   [2];
  logic [31:0] dp1   [2];
  logic [31:0] dpr   [2];
  logic [10:0] last_op  [2];
  logic [31:0] last_a   [2];
  logic [31:0] last_b   [2];
  logic [31:0] last_res [2];
  int n_cmp = 0;
  int n_bad = 0;
  // Datapath stand-in: exact values for the directed float cases, a mixing hash otherwise
  function automatic logic [31:0] fdp(input logic [10:0] op, input logic [31:0] x, input logic [31:0] y);
    if (op == 11'd0 && x == 32'h3F800000 && y == 32'h40000000) return 32'h40400000;
    if (op == 11'd3 && x == 32'h40C00000 && y == 32'h40000000) return 32'h40400000;
    if (op == 11'd2 && x == 32'h40400000 && y == 32'h40800000) return 32'h41400000;
    if (op == 11'd1 && x == 32'h40400000 && y == 32'h3F800000) return 32'h40000000;
    return (x ^ {y[15:0], y[31:16]}) + {21'd0, op} * 32'h9E3779B9 + 32'h1;
  endfunction
  always_comb begin
    dpr[0] = fdp(dpo[0], dp0[0], dp1[0]);
    dpr[1] = fdp(dpo[1], dp0[1], dp1[1]);
  end
  float_copro_ctrl #(.LATENCY(4), .NUM_OPS(4)) u_l4 (
    .clk(clk), .rst_n(rst_n[0]), .user_valid(v[0]), .user_opcode(opc[0]),
    .user_operand_0(a[0]), .user_operand_1(b[0]), .user_result(res[0]),
    .user_complete(cmp[0]), .user_error(err[0]), .busy(bsy[0]),
    .dp_opcode(dpo[0]), .dp_op0(dp0[0]), .dp_op1(dp1[0]), .dp_result(dpr[0])
  );
  float_copro_ctrl #(.LATENCY(1), .NUM_OPS(4)) u_l1 (
    .clk(clk), .rst_n(rst_n[1]), .user_valid(v[1]), .user_opcode(opc[1]),
    .user_operand_0(a[1]), .user_operand_1(b[1]), .user_result(res[1]),
    .user_complete(cmp[1]), .user_error(err[1]), .busy(bsy[1]),
    .dp_opcode(dpo[1]), .dp_op0(dp0[1]), .dp_op1(dp1[1]), .dp_result(dpr[1])
  );
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s @%0t: got %h expected %h", tag, $time, got, exp);
    end
  endtask
  // One request; the model says completion lands lat edges after the sampling edge
  task automatic txn(input int k, input logic [10:0] op, input logic [31:0] x, input logic [31:0] y, input bit wiggle);
    bit ill;
    int lat;
    logic [31:0] exp;
    ill = op >= 11'd4;
    lat = ill ? 1 : ((k == 0) ? 5 : 2);
    exp = ill ? 32'd0 : fdp(op, x, y);
    v[k] = 1'b1; opc[k] = op; a[k] = x; b[k] = y;
    for (int c = 0; c <= lat; c++) begin
      @(negedge clk);
      if (c < lat) begin
        check("busy_hi", bsy[k], 1);
        check("complete_lo", cmp[k], 0);
        check("dp_opcode", dpo[k], ill ? last_op[k] : op);
        check("dp_op0", dp0[k], ill ? last_a[k] : x);
        check("dp_op1", dp1[k], ill ? last_b[k] : y);
        if (c == 0 && !ill) check("result_hold", res[k], last_res[k]);
        if (wiggle) begin
          v[k] = 1'($urandom); opc[k] = 11'($urandom); a[k] = $urandom; b[k] = $urandom;
        end
      end else begin
        check("busy_lo", bsy[k], 0);
        check("complete", cmp[k], 1);
        check("error", err[k], ill);
        check("result", res[k], exp);
      end
    end
    if (!ill) begin
      last_op[k] = op; last_a[k] = x; last_b[k] = y;
    end
    last_res[k] = exp;
  endtask
  task automatic idle(input int k, input int n);
    v[k] = 1'b0;
    repeat (n) begin
      @(negedge clk);
      check("idle_complete", cmp[k], 0);
      check("idle_busy", bsy[k], 0);
      check("idle_result", res[k], last_res[k]);
    end
  endtask
  task automatic check_zero(input int k);
    check("rst_result", res[k], 0);
    check("rst_complete", cmp[k], 0);
    check("rst_error", err[k], 0);
    check("rst_busy", bsy[k], 0);
    check("rst_dp_opcode", dpo[k], 0);
    check("rst_dp_op0", dp0[k], 0);
    check("rst_dp_op1", dp1[k], 0);
  endtask
  task automatic reset_mid(input int k);
    v[k] = 1'b1; opc[k] = 11'd2; a[k] = $urandom; b[k] = $urandom;
    repeat (2) @(negedge clk);
    rst_n[k] = 1'b0; v[k] = 1'b0;
    @(negedge clk);
    check_zero(k);
    rst_n[k] = 1'b1;
    last_op[k] = 11'd0; last_a[k] = 32'd0; last_b[k] = 32'd0; last_res[k] = 32'd0;
    idle(k, 7);
  endtask
  task automatic rand_run(input int k, input int n);
    logic [10:0] op;
    for (int i = 0; i < n; i++) begin
      op = ($urandom_range(0, 4) == 0) ? 11'($urandom) : 11'($urandom_range(0, 4));
      txn(k, op, $urandom, $urandom, 1'($urandom));
      if ($urandom_range(0, 2) == 0) idle(k, $urandom_range(1, 3));
    end
  endtask
  initial begin
    for (int k = 0; k < 2; k++) begin
      rst_n[k] = 1'b0; v[k] = 1'b0; opc[k] = 11'd0; a[k] = 32'd0; b[k] = 32'd0;
      last_op[k] = 11'd0; last_a[k] = 32'd0; last_b[k] = 32'd0; last_res[k] = 32'd0;
    end
    repeat (2) @(negedge clk);
    check_zero(0);
    check_zero(1);
    rst_n[0] = 1'b1; rst_n[1] = 1'b1;
    idle(0, 2);
    txn(0, 11'd0, 32'h3F800000, 32'h40000000, 1'b0);
    idle(0, 1);
    txn(0, 11'd3, 32'h40C00000, 32'h40000000, 1'b0);
    txn(0, 11'd2, 32'h40400000, 32'h40800000, 1'b0);
    idle(0, 2);
    txn(0, 11'd7, 32'h12345678, 32'h9ABCDEF0, 1'b0);
    idle(0, 1);
    txn(0, 11'd0, 32'h3F800000, 32'h40000000, 1'b1);
    idle(0, 1);
    reset_mid(0);
    txn(0, 11'd0, 32'h3F800000, 32'h40000000, 1'b0);
    idle(0, 1);
    txn(1, 11'd1, 32'h40400000, 32'h3F800000, 1'b0);
    txn(1, 11'h7FF, 32'hDEADBEEF, 32'h0BADF00D, 1'b0);
    idle(1, 1);
    rand_run(0, 40);
    idle(0, 1);
    rand_run(1, 40);
    idle(1, 1);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/float_copro_ctrl.md
Name: float_copro_ctrl

Overview:
Sequencing front-end of the floating-point coprocessor. It sits between the LM32 user-defined-instruction port and the combinational float datapath (float add/sub/mul/div unit). It captures the opcode and operands on a request and holds them stable for a fixed number of cycles, because the datapath is a multicycle path. It then registers the datapath result and returns it with a one-cycle completion pulse.

Parameters:
LATENCY, 4, cycles the datapath inputs are held before dp_result is sampled; legal range 1..15.
NUM_OPS, 4, number of legal opcodes (0..NUM_OPS-1); higher opcodes are illegal.

Ports:
clk  input  1  single clock, all state on rising edge
rst_n  input  1  synchronous active-low reset
user_valid  input  1  request from CPU; held high until user_complete is seen
user_opcode  input  11  operation select (0 add, 1 sub, 2 mul, 3 div)
user_operand_0  input  32  IEEE-754 single operand A
user_operand_1  input  32  IEEE-754 single operand B
user_result  output  32  registered result, valid while user_complete=1
user_complete  output  1  one-cycle completion pulse
user_error  output  1  one-cycle pulse with user_complete when opcode was illegal
busy  output  1  high in EXEC and DONE
dp_opcode  output  11  held opcode to datapath
dp_op0  output  32  held operand A to datapath
dp_op1  output  32  held operand B to datapath
dp_result  input  32  combinational datapath result

Behaviour:
- Reset (rst_n=0 at a rising edge): state IDLE, cycle counter 0, user_result 0, user_complete 0, user_error 0, busy 0, dp_opcode/dp_op0/dp_op1 0. Reset mid-operation abandons the operation; no complete pulse is issued.
- FSM states: IDLE, EXEC, DONE.
- IDLE with user_valid=1 and opcode < NUM_OPS: capture opcode and operands into the dp_* registers, load counter with LATENCY-1, go to EXEC.
- IDLE with user_valid=1 and opcode >= NUM_OPS: do not change the dp_* registers, set user_result to 0, go to DONE with user_error flagged.
- IDLE with user_valid=0: stay in IDLE.
- EXEC: dp_* registers are frozen. Input changes, including user_valid, are ignored. Each cycle the counter decrements.
- EXEC with counter=0: register dp_result into user_result, go to DONE.
- DONE: user_complete=1 for exactly one cycle, user_error=1 only for an illegal opcode, then go to IDLE.
- Latency: the request is sampled at edge N. For a legal opcode, user_complete is high in the cycle after edge N+LATENCY+1. For an illegal opcode, user_complete is high in the cycle after edge N+1.
- Throughput: user_valid high in the cycle after DONE starts a new request (back-to-back). The requester must drop user_valid in the cycle it sees user_complete unless issuing a new request.
- user_result holds its value after DONE until the next completion overwrites it.
- dp_* keep the last captured values in IDLE, which avoids needless datapath toggling.
- busy = (state != IDLE).
- LATENCY=1: EXEC lasts exactly one cycle.

Test Plan:
- Add, LATENCY=4: opcode 0, 0x3F800000 + 0x40000000, valid at edge 0 -> dp_* stable over edges 1..4; user_result=0x40400000 with user_complete high for 1 cycle after edge 5; busy high over edges 1..5.
- Back-to-back: div 0x40C00000/0x40000000 immediately followed by mul 0x40400000*0x40800000 -> completions with 0x40400000 then 0x41400000; 6 cycles apart with no idle gap.
- Illegal opcode 7, valid at edge 0 -> complete and error high after edge 1; user_result=0; dp_* unchanged from previous values.
- Operand change during EXEC: change user_operand_0 at edge 2 -> dp_op0 keeps the captured value; result matches the original operands.
- Reset mid-EXEC: rst_n=0 at edge 2 -> outputs zeroed next cycle; no user_complete; a fresh request afterward completes normally.
- LATENCY=1 build: sub 0x40400000-0x3F800000 -> user_result=0x40000000 with complete after edge 2.
